// File: rtl/syst_dft_ctrl.sv
// Frame sequencer for the systolic DFT array: buffers one frame of samples, replays it once
// per bin with that bin's twiddle row loaded into the nodes, and tags each array result.
module syst_dft_ctrl #(
    parameter int unsigned W_WIDTH      = 16,
    parameter int unsigned X_WIDTH      = 16,
    parameter int unsigned S_WIDTH      = 32,
    parameter int unsigned FRAME_LENGTH = 4,
    parameter int unsigned N_BINS       = 4,
    localparam int unsigned K_WIDTH     = (N_BINS > 1) ? $clog2(N_BINS) : 1
) (
    input  logic                                   clk,
    input  logic                                   arstn,
    input  logic [FRAME_LENGTH-1:0][W_WIDTH-1:0]   tw_re,
    input  logic [FRAME_LENGTH-1:0][W_WIDTH-1:0]   tw_im,
    input  logic                                   s_valid,
    output logic                                   s_ready,
    input  logic [X_WIDTH-1:0]                     s_data,
    output logic                                   arr_enable,
    output logic [FRAME_LENGTH-1:0][W_WIDTH-1:0]   arr_w_re,
    output logic [FRAME_LENGTH-1:0][W_WIDTH-1:0]   arr_w_im,
    output logic [FRAME_LENGTH-1:0]                arr_valid_x,
    output logic [X_WIDTH-1:0]                     arr_x,
    input  logic [S_WIDTH-1:0]                     arr_re,
    input  logic [S_WIDTH-1:0]                     arr_im,
    input  logic                                   arr_valid,
    output logic                                   m_valid,
    output logic [S_WIDTH-1:0]                     m_re,
    output logic [S_WIDTH-1:0]                     m_im,
    output logic [K_WIDTH-1:0]                     m_k,
    output logic                                   m_last
);

    localparam int unsigned IdxWidth = $clog2(FRAME_LENGTH);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(FRAME_LENGTH - 1);
    localparam logic [IdxWidth:0] NLen = (IdxWidth + 1)'(FRAME_LENGTH);
    localparam logic [K_WIDTH-1:0] LastBin = K_WIDTH'(N_BINS - 1);
    localparam logic [FRAME_LENGTH-1:0] FirstNode = {1'b1, {(FRAME_LENGTH - 1){1'b0}}};

    typedef enum logic [1:0] {StFill, StLoad, StRun, StWait} state_e;

    state_e                                state_q, state_d;
    logic [IdxWidth-1:0]                   wcnt_q, wcnt_d;
    logic [IdxWidth-1:0]                   c_q, c_d;
    logic [K_WIDTH-1:0]                    k_q, k_d;
    logic [FRAME_LENGTH-1:0][X_WIDTH-1:0]  buf_q, buf_d;
    logic                                  arr_enable_q, arr_enable_d;
    logic [FRAME_LENGTH-1:0][W_WIDTH-1:0]  arr_w_re_q, arr_w_re_d;
    logic [FRAME_LENGTH-1:0][W_WIDTH-1:0]  arr_w_im_q, arr_w_im_d;
    logic [FRAME_LENGTH-1:0]               arr_valid_x_q, arr_valid_x_d;
    logic [X_WIDTH-1:0]                    arr_x_q, arr_x_d;
    logic                                  m_valid_q, m_valid_d;
    logic [S_WIDTH-1:0]                    m_re_q, m_re_d;
    logic [S_WIDTH-1:0]                    m_im_q, m_im_d;
    logic [K_WIDTH-1:0]                    m_k_q, m_k_d;
    logic                                  m_last_q, m_last_d;

    logic [IdxWidth:0]                     run_sum;
    logic [FRAME_LENGTH-1:0][IdxWidth-1:0] tw_idx;

    // Twiddle index (k*i) mod N as a running modular sum along the nodes.
    always_comb begin
        run_sum = '0;
        tw_idx  = '0;
        for (int unsigned i = 0; i < FRAME_LENGTH; i++) begin
            tw_idx[i] = run_sum[IdxWidth-1:0];
            run_sum   = run_sum + (IdxWidth + 1)'(k_q);
            if (run_sum >= NLen) begin
                run_sum = run_sum - NLen;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        wcnt_d        = wcnt_q;
        c_d           = c_q;
        k_d           = k_q;
        buf_d         = buf_q;
        arr_enable_d  = arr_enable_q;
        arr_w_re_d    = arr_w_re_q;
        arr_w_im_d    = arr_w_im_q;
        arr_valid_x_d = arr_valid_x_q;
        arr_x_d       = arr_x_q;
        m_valid_d     = 1'b0;
        m_re_d        = m_re_q;
        m_im_d        = m_im_q;
        m_k_d         = m_k_q;
        m_last_d      = m_last_q;

        unique case (state_q)
            StFill: begin
                if (s_valid) begin
                    buf_d[wcnt_q] = s_data;
                    if (wcnt_q == LastIdx) begin
                        wcnt_d  = '0;
                        k_d     = '0;
                        state_d = StLoad;
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                end
            end
            StLoad: begin
                for (int unsigned i = 0; i < FRAME_LENGTH; i++) begin
                    arr_w_re_d[i] = tw_re[tw_idx[i]];
                    arr_w_im_d[i] = tw_im[tw_idx[i]];
                end
                c_d           = '0;
                arr_enable_d  = 1'b1;
                arr_valid_x_d = FirstNode;
                arr_x_d       = buf_q[0];
                state_d       = StRun;
            end
            StRun: begin
                // Output registers already hold cycle c; prepare cycle c+1.
                if (c_q == LastIdx) begin
                    arr_valid_x_d = '0;
                    arr_x_d       = '0;
                    state_d       = StWait;
                end else begin
                    c_d           = c_q + 1'b1;
                    arr_valid_x_d = arr_valid_x_q >> 1;
                    arr_x_d       = buf_q[c_q + 1'b1];
                end
            end
            StWait: begin
                if (arr_valid) begin
                    m_valid_d = 1'b1;
                    m_re_d    = arr_re;
                    m_im_d    = arr_im;
                    m_k_d     = k_q;
                    m_last_d  = (k_q == LastBin);
                    if (k_q == LastBin) begin
                        arr_enable_d = 1'b0;
                        state_d      = StFill;
                    end else begin
                        k_d     = k_q + 1'b1;
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StFill;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arstn) begin
            state_q       <= StFill;
            wcnt_q        <= '0;
            c_q           <= '0;
            k_q           <= '0;
            buf_q         <= '0;
            arr_enable_q  <= 1'b0;
            arr_w_re_q    <= '0;
            arr_w_im_q    <= '0;
            arr_valid_x_q <= '0;
            arr_x_q       <= '0;
            m_valid_q     <= 1'b0;
            m_re_q        <= '0;
            m_im_q        <= '0;
            m_k_q         <= '0;
            m_last_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            wcnt_q        <= wcnt_d;
            c_q           <= c_d;
            k_q           <= k_d;
            buf_q         <= buf_d;
            arr_enable_q  <= arr_enable_d;
            arr_w_re_q    <= arr_w_re_d;
            arr_w_im_q    <= arr_w_im_d;
            arr_valid_x_q <= arr_valid_x_d;
            arr_x_q       <= arr_x_d;
            m_valid_q     <= m_valid_d;
            m_re_q        <= m_re_d;
            m_im_q        <= m_im_d;
            m_k_q         <= m_k_d;
            m_last_q      <= m_last_d;
        end
    end

    assign s_ready     = (state_q == StFill);
    assign arr_enable  = arr_enable_q;
    assign arr_w_re    = arr_w_re_q;
    assign arr_w_im    = arr_w_im_q;
    assign arr_valid_x = arr_valid_x_q;
    assign arr_x       = arr_x_q;
    assign m_valid     = m_valid_q;
    assign m_re        = m_re_q;
    assign m_im        = m_im_q;
    assign m_k         = m_k_q;
    assign m_last      = m_last_q;

endmodule

// File: tb/tb_syst_dft_ctrl.sv
// Bench for syst_dft_ctrl: behavioural array model in the loopback, scoreboard of expected
// DFT bins per frame, plus a directed run of a single-bin instance.
module tb_syst_dft_ctrl;

    localparam int N  = 4;
    localparam int NB = 4;

    typedef struct {
        longint re;
        longint im;
        int     k;
        bit     last;
    } res_t;

    logic                clk = 1'b0;
    logic                arstn;
    logic [N-1:0][15:0]  tw_re, tw_im;
    logic                s_valid, s_ready;
    logic [15:0]         s_data;
    logic                arr_enable;
    logic [N-1:0][15:0]  arr_w_re, arr_w_im;
    logic [N-1:0]        arr_valid_x;
    logic [15:0]         arr_x;
    logic [31:0]         arr_re, arr_im;
    logic                arr_valid;
    logic                m_valid;
    logic [31:0]         m_re, m_im;
    logic [1:0]          m_k;
    logic                m_last;

    logic                s_valid1, s_ready1;
    logic [15:0]         s_data1;
    logic                arr_enable1;
    logic [N-1:0][15:0]  arr_w_re1, arr_w_im1;
    logic [N-1:0]        arr_valid_x1;
    logic [15:0]         arr_x1;
    logic [31:0]         arr_re1, arr_im1;
    logic                arr_valid1;
    logic                m_valid1;
    logic [31:0]         m_re1, m_im1;
    logic [0:0]          m_k1;
    logic                m_last1;

    syst_dft_ctrl #(.FRAME_LENGTH(N), .N_BINS(NB)) u_dut (
        .clk(clk), .arstn(arstn), .tw_re(tw_re), .tw_im(tw_im),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .arr_enable(arr_enable), .arr_w_re(arr_w_re), .arr_w_im(arr_w_im),
        .arr_valid_x(arr_valid_x), .arr_x(arr_x),
        .arr_re(arr_re), .arr_im(arr_im), .arr_valid(arr_valid),
        .m_valid(m_valid), .m_re(m_re), .m_im(m_im), .m_k(m_k), .m_last(m_last)
    );

    syst_dft_ctrl #(.FRAME_LENGTH(N), .N_BINS(1)) u_dut1 (
        .clk(clk), .arstn(arstn), .tw_re(tw_re), .tw_im(tw_im),
        .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data1),
        .arr_enable(arr_enable1), .arr_w_re(arr_w_re1), .arr_w_im(arr_w_im1),
        .arr_valid_x(arr_valid_x1), .arr_x(arr_x1),
        .arr_re(arr_re1), .arr_im(arr_im1), .arr_valid(arr_valid1),
        .m_valid(m_valid1), .m_re(m_re1), .m_im(m_im1), .m_k(m_k1), .m_last(m_last1)
    );

    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_errors = 0;
    res_t   sb[$];
    res_t   exp_r;
    int     twr[N];
    int     twi[N];
    int     cur_frame[N];
    int     res_cnt = 0;
    int     lat_cfg = 0;
    bit     spur_req = 1'b0;

    task automatic check_eq(input string tag, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Array model: accumulates x*w per strobed node, answers L cycles after the last strobe.
    int     node_cnt = 0;
    int     lat_cnt = 0;
    int     bin_idx = 0;
    int     node;
    longint acc_re = 0;
    longint acc_im = 0;

    always @(negedge clk) begin
        arr_valid = 1'b0;
        if (!arstn) begin
            node_cnt = 0;
            acc_re   = 0;
            acc_im   = 0;
            bin_idx  = 0;
        end else if (arr_enable && arr_valid_x != '0) begin
            node = N - 1;
            for (int b = 0; b < N; b++) begin
                if (arr_valid_x[b]) node = N - 1 - b;
            end
            if (node_cnt < N) begin
                check_eq("run_valid_x", arr_valid_x, 1 << (N - 1 - node_cnt));
                check_eq("run_arr_x", $signed(arr_x), cur_frame[node_cnt]);
                check_eq("run_w_re", $signed(arr_w_re[node_cnt]), twr[(bin_idx * node_cnt) % N]);
                check_eq("run_w_im", $signed(arr_w_im[node_cnt]), twi[(bin_idx * node_cnt) % N]);
                check_eq("run_s_ready", s_ready, 0);
            end
            acc_re += $signed(arr_x) * $signed(arr_w_re[node]);
            acc_im += $signed(arr_x) * $signed(arr_w_im[node]);
            if (node_cnt == 0) lat_cnt = lat_cfg;
            node_cnt++;
        end else if (node_cnt >= N) begin
            if (lat_cnt == 0) begin
                arr_valid = 1'b1;
                arr_re    = 32'(acc_re);
                arr_im    = 32'(acc_im);
                acc_re    = 0;
                acc_im    = 0;
                node_cnt  = 0;
                bin_idx   = (bin_idx == NB - 1) ? 0 : bin_idx + 1;
            end else begin
                lat_cnt--;
            end
        end else if (spur_req && node_cnt == 0) begin
            arr_valid = 1'b1;
            arr_re    = 32'd999;
            arr_im    = -32'sd7;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            res_cnt++;
            if (sb.size() == 0) begin
                check_eq("unexpected_m_valid", m_valid, 0);
            end else begin
                exp_r = sb.pop_front();
                check_eq("m_re", $signed(m_re), exp_r.re);
                check_eq("m_im", $signed(m_im), exp_r.im);
                check_eq("m_k", m_k, exp_r.k);
                check_eq("m_last", m_last, exp_r.last);
                if (exp_r.last) check_eq("s_ready_at_last", s_ready, 1);
            end
        end
    end

    task automatic feed(input int xs[N], input bit [6:0] pat);
        int   idx = 0;
        int   step = 0;
        bit   v, acc;
        int   frame[N];
        res_t r;
        while (idx < N && step < 500) begin
            v       = (step < 7) ? pat[6 - step] : 1'b1;
            s_valid = v;
            s_data  = 16'(xs[idx]);
            acc     = v && s_ready;
            @(posedge clk);
            if (acc) begin
                frame[idx] = xs[idx];
                idx++;
            end
            @(negedge clk);
            step++;
        end
        s_valid = 1'b0;
        check_eq("frame_accepted", idx, N);
        if (idx == N) begin
            cur_frame = frame;
            for (int k = 0; k < NB; k++) begin
                r.re = 0;
                r.im = 0;
                for (int n = 0; n < N; n++) begin
                    r.re += longint'(frame[n]) * twr[(k * n) % N];
                    r.im += longint'(frame[n]) * twi[(k * n) % N];
                end
                r.k    = k;
                r.last = (k == NB - 1);
                sb.push_back(r);
            end
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((sb.size() != 0 || !s_ready) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_eq("pending_results", sb.size(), 0);
    endtask

    task automatic check_reset0();
        check_eq("rst_s_ready", s_ready, 1);
        check_eq("rst_arr_enable", arr_enable, 0);
        check_eq("rst_arr_valid_x", arr_valid_x, 0);
        check_eq("rst_arr_x", arr_x, 0);
        check_eq("rst_arr_w_re", arr_w_re, 0);
        check_eq("rst_arr_w_im", arr_w_im, 0);
        check_eq("rst_m_valid", m_valid, 0);
        check_eq("rst_m_re", m_re, 0);
        check_eq("rst_m_im", m_im, 0);
        check_eq("rst_m_k", m_k, 0);
        check_eq("rst_m_last", m_last, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base, t, spur_base;
        twr = '{16384, 0, -16384, 0};
        twi = '{0, -16384, 0, 16384};
        for (int i = 0; i < N; i++) begin
            tw_re[i] = 16'(twr[i]);
            tw_im[i] = 16'(twi[i]);
        end
        arstn = 1'b0; s_valid = 1'b0; s_data = '0;
        s_valid1 = 1'b0; s_data1 = '0; arr_valid1 = 1'b0; arr_re1 = '0; arr_im1 = '0;
        repeat (3) @(negedge clk);
        check_reset0();
        check_eq("rst1_s_ready", s_ready1, 1);
        check_eq("rst1_m_valid", m_valid1, 0);
        arstn = 1'b1;
        @(negedge clk);

        lat_cfg = 0;
        feed('{1, 0, 0, 0}, 7'b1111111);
        wait_idle();
        lat_cfg = 2;
        feed('{1, 1, 1, 1}, 7'b1111111);
        wait_idle();
        lat_cfg = 1;
        feed('{3, -5, 7, 11}, 7'b1001101);
        wait_idle();

        // Array result while filling must not produce an output.
        spur_base = res_cnt;
        @(negedge clk) spur_req = 1'b1;
        @(negedge clk) spur_req = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("spurious_results", res_cnt - spur_base, 0);
        check_eq("spurious_s_ready", s_ready, 1);

        // Reset during RUN of bin 2.
        lat_cfg = 3;
        base = res_cnt;
        feed('{5, 6, 7, 8}, 7'b1111111);
        t = 0;
        while (res_cnt < base + 2 && t < 2000) begin @(negedge clk); t++; end
        while (arr_valid_x == '0 && t < 2000) begin @(negedge clk); t++; end
        check_eq("reached_run_k2", res_cnt - base, 2);
        arstn = 1'b0;
        @(negedge clk);
        check_reset0();
        sb.delete();
        @(negedge clk);
        arstn = 1'b1;
        lat_cfg = 0;
        feed('{2, 0, 0, 0}, 7'b1111111);
        wait_idle();

        // Single-bin instance.
        for (int i = 0; i < N; i++) begin
            s_valid1 = 1'b1;
            s_data1  = 16'(i + 1);
            check_eq("n1_s_ready", s_ready1, 1);
            @(negedge clk);
        end
        s_valid1 = 1'b0;
        t = 0;
        while (arr_valid_x1 == '0 && t < 100) begin @(negedge clk); t++; end
        check_eq("n1_w_re_k0", $signed(arr_w_re1[2]), twr[0]);
        while (arr_valid_x1 != '0 && t < 100) begin @(negedge clk); t++; end
        check_eq("n1_run_done", t < 100, 1);
        arr_valid1 = 1'b1;
        arr_re1    = 32'd1234;
        arr_im1    = -32'sd56;
        @(negedge clk);
        arr_valid1 = 1'b0;
        check_eq("n1_m_valid", m_valid1, 1);
        check_eq("n1_m_re", $signed(m_re1), 1234);
        check_eq("n1_m_im", $signed(m_im1), -56);
        check_eq("n1_m_k", m_k1, 0);
        check_eq("n1_m_last", m_last1, 1);
        check_eq("n1_s_ready", s_ready1, 1);
        @(negedge clk);
        check_eq("n1_m_valid_pulse", m_valid1, 0);
        check_eq("n1_arr_enable", arr_enable1, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
